// File: rtl/window_integrator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_integrator_pkg
// Purpose  : Shared types and constants for the triggered window integrator.
//            Holds the controller state encoding, the default data/control
//            widths and a helper giving the smallest sum width that cannot
//            wrap for a full-length window of full-scale samples.
// Revision : 1.0  initial release
// ============================================================================
package window_integrator_pkg;

    localparam int c_DEF_DATA_W = 13;
    localparam int c_DEF_WIN_W  = 8;
    localparam int c_DEF_SUM_W  = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_INTEG = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // One extra bit covers the baseline-subtracted term, which is DATA_W+1
    // bits wide before accumulation over up to 2**WIN_W-1 samples.
    function automatic int min_sum_w(input int data_w, input int win_w);
        return data_w + win_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_integrator.sv
`default_nettype none
// ============================================================================
// Module   : window_integrator
// Purpose  : On each accepted trigger, waits 'delay' samples and then sums
//            'width' consecutive signed samples. The sum is offered on a
//            valid/ready output and held until the consumer takes it.
// Revision : 1.0  initial release
//
// Ports    : clk        sample clock, one sample per cycle
//            rst_n      asynchronous active-low reset
//            in         signed input sample (DATA_W)
//            trig       trigger strobe
//            delay      trigger-to-first-sample distance, 0..2**WIN_W-1
//            width      number of samples summed; 0 ignores the trigger
//            sum_out    signed window sum (SUM_W)
//            sum_valid  sum_out holds an unconsumed result
//            sum_ready  consumer accepts sum_out
//            busy       a window is pending, running or waiting for handoff
//            overrun    one-cycle pulse for a dropped trigger
//
// Config   : WINDOW_INTEGRATOR_BASELINE_EN -- when defined, each summed term
//            is the sample minus the sample latched at the trigger edge.
//            SUM_W must be at least min_sum_w(DATA_W, WIN_W) in both builds.
// ============================================================================
module window_integrator
    import window_integrator_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int WIN_W  = c_DEF_WIN_W,
    parameter int SUM_W  = c_DEF_SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              trig,
    input  logic [WIN_W-1:0]  delay,
    input  logic [WIN_W-1:0]  width,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              overrun
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIN_W-1:0]   r_cnt;
    logic [WIN_W-1:0]   w_cnt_nxt;
    logic [WIN_W-1:0]   r_width;
    logic [WIN_W-1:0]   w_width_nxt;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   w_acc_nxt;
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic [SUM_W-1:0]   w_term;
    logic               w_trig_live;
    logic               w_accept;

    // A zero-width trigger is treated as no trigger at all: never accepted
    // and never counted as an overrun.
    assign w_trig_live = trig && (width != '0);

    // New windows start from IDLE, or from HOLD on the very edge that the
    // pending result is handed off.
    assign w_accept = w_trig_live &&
                      ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && sum_ready));

    // ------------------------------------------------------------------
    // Per-sample term added to the accumulator
    // ------------------------------------------------------------------
`ifdef WINDOW_INTEGRATOR_BASELINE_EN
    logic [DATA_W-1:0] r_base;
    logic [DATA_W:0]   w_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
        end else if (w_accept) begin
            r_base <= in;
        end
    end

    // Both operands are sign-extended by one bit so the difference of two
    // DATA_W-bit values cannot wrap.
    assign w_diff = {in[DATA_W-1], in} - {r_base[DATA_W-1], r_base};
    assign w_term = {{(SUM_W-DATA_W-1){w_diff[DATA_W]}}, w_diff};
`else
    assign w_term = {{(SUM_W-DATA_W){in[DATA_W-1]}}, in};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_width_nxt   = r_width;
        w_acc_nxt     = r_acc;
        w_sum_nxt     = r_sum;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Acceptance handled below.
            end

            ST_DELAY: begin
                w_overrun_nxt = w_trig_live;
                w_cnt_nxt     = r_cnt - 1'b1;
                // Counter was loaded with delay at the trigger edge, so the
                // edge that sees 1 is edge k+delay; summing starts next edge.
                if (r_cnt == WIN_W'(1)) begin
                    w_state_nxt = ST_INTEG;
                    w_cnt_nxt   = r_width;
                end
            end

            ST_INTEG: begin
                w_overrun_nxt = w_trig_live;
                w_acc_nxt     = r_acc + w_term;
                w_cnt_nxt     = r_cnt - 1'b1;
                if (r_cnt == WIN_W'(1)) begin
                    w_sum_nxt   = r_acc + w_term;
                    w_valid_nxt = 1'b1;
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (sum_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_overrun_nxt = w_trig_live;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_width_nxt = width;
            w_acc_nxt   = '0;
            if (delay != '0) begin
                w_state_nxt = ST_DELAY;
                w_cnt_nxt   = delay;
            end else begin
                w_state_nxt = ST_INTEG;
                w_cnt_nxt   = width;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_width   <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_width   <= w_width_nxt;
            r_acc     <= w_acc_nxt;
            r_sum     <= w_sum_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign sum_out   = r_sum;
    assign sum_valid = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
